// File: rtl/l2_request_arbiter_if.sv
// l2_request_arbiter_if: both L1 snooper request/response ports plus the shared memory port
interface l2_request_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 128
);
   logic [ADDR_W-1:0] a_addr;
   logic [ADDR_W-1:0] b_addr;
   logic [ADDR_W-1:0] mem_addr;
   logic [LINE_W-1:0] a_wdata;
   logic [LINE_W-1:0] b_wdata;
   logic [LINE_W-1:0] a_rdata;
   logic [LINE_W-1:0] b_rdata;
   logic [LINE_W-1:0] mem_wdata;
   logic [LINE_W-1:0] mem_rdata;
   logic a_wren, a_rden, a_req_ready, a_rdata_valid;
   logic b_wren, b_rden, b_req_ready, b_rdata_valid;
   logic mem_wren, mem_rden, mem_rdata_valid;
   logic overflow, orphan_resp;
   modport slave (
      input  a_addr, a_wdata, a_wren, a_rden,
      input  b_addr, b_wdata, b_wren, b_rden,
      input  mem_rdata, mem_rdata_valid,
      output a_req_ready, a_rdata, a_rdata_valid,
      output b_req_ready, b_rdata, b_rdata_valid,
      output mem_addr, mem_wdata, mem_wren, mem_rden,
      output overflow, orphan_resp
   );
   modport master (
      output a_addr, a_wdata, a_wren, a_rden,
      output b_addr, b_wdata, b_wren, b_rden,
      output mem_rdata, mem_rdata_valid,
      input  a_req_ready, a_rdata, a_rdata_valid,
      input  b_req_ready, b_rdata, b_rdata_valid,
      input  mem_addr, mem_wdata, mem_wren, mem_rden,
      input  overflow, orphan_resp
   );
endinterface

// File: rtl/l2_request_arbiter.sv
// l2_request_arbiter: round-robin merge of two L1 request FIFOs onto one in-order memory port
module l2_request_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int LINE_W     = 128,
   parameter int FIFO_DEPTH = 4,
   parameter int MAX_OUT    = 8
) (
   input logic clk,
   input logic reset,
   l2_request_arbiter_if.slave bus
);
   localparam int FPW = $clog2(FIFO_DEPTH);
   localparam int FCW = $clog2(FIFO_DEPTH + 1);
   localparam int TPW = $clog2(MAX_OUT);
   localparam int TCW = $clog2(MAX_OUT + 1);
   typedef struct packed {
      logic              wr;
      logic              rd;
      logic [ADDR_W-1:0] addr;
      logic [LINE_W-1:0] wdata;
   } req_t;
   req_t              fifo_q [2][FIFO_DEPTH];
   logic [FPW-1:0]    wp_q [2];
   logic [FPW-1:0]    rp_q [2];
   logic [FCW-1:0]    cnt_q [2];
   logic [MAX_OUT-1:0] tag_q;
   logic [TPW-1:0]    twp_q;
   logic [TPW-1:0]    trp_q;
   logic [TCW-1:0]    tcnt_q;
   logic              rr_last_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [LINE_W-1:0] mem_wdata_q;
   logic              mem_wren_q;
   logic              mem_rden_q;
   logic              overflow_q;
   logic              orphan_q;
   logic [LINE_W-1:0] rdata_q [2];
   logic [1:0]        rvalid_q;
   req_t              in_req [2];
   req_t              head [2];
   req_t              sel;
   logic [1:0]        req_v;
   logic [1:0]        ready;
   logic [1:0]        push;
   logic [1:0]        elig;
   logic [1:0]        gnt;
   logic              gnt_id;
   logic              tag_full;
   logic              tag_push;
   logic              tag_pop;
   logic              tag_id;
   assign in_req[0] = '{wr: bus.a_wren, rd: bus.a_rden, addr: bus.a_addr, wdata: bus.a_wdata};
   assign in_req[1] = '{wr: bus.b_wren, rd: bus.b_rden, addr: bus.b_addr, wdata: bus.b_wdata};
   assign tag_full  = tcnt_q == TCW'(MAX_OUT);
   // a read head stalls on a full tag FIFO even if a response frees a slot this edge
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         head[p]  = fifo_q[p][rp_q[p]];
         req_v[p] = in_req[p].wr | in_req[p].rd;
         ready[p] = cnt_q[p] != FCW'(FIFO_DEPTH);
         push[p]  = req_v[p] & ready[p];
         elig[p]  = (cnt_q[p] != '0) & (!head[p].rd | !tag_full);
      end
   end
   assign gnt[0]   = elig[0] & (!elig[1] | rr_last_q);
   assign gnt[1]   = elig[1] & (!elig[0] | !rr_last_q);
   assign gnt_id   = gnt[1];
   assign sel      = head[gnt_id];
   assign tag_push = |gnt & sel.rd;
   assign tag_pop  = bus.mem_rdata_valid & (tcnt_q != '0);
   assign tag_id   = tag_q[trp_q];
   always_ff @(posedge clk) begin
      for (int p = 0; p < 2; p++)
         if (push[p]) fifo_q[p][wp_q[p]] <= in_req[p];
      if (tag_push) tag_q[twp_q] <= gnt_id;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int p = 0; p < 2; p++) begin
            wp_q[p]    <= '0;
            rp_q[p]    <= '0;
            cnt_q[p]   <= '0;
            rdata_q[p] <= '0;
         end
         twp_q       <= '0;
         trp_q       <= '0;
         tcnt_q      <= '0;
         rr_last_q   <= 1'b1;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wren_q  <= 1'b0;
         mem_rden_q  <= 1'b0;
         rvalid_q    <= '0;
         overflow_q  <= 1'b0;
         orphan_q    <= 1'b0;
      end else begin
         for (int p = 0; p < 2; p++) begin
            if (push[p]) wp_q[p] <= wp_q[p] + FPW'(1);
            if (gnt[p]) rp_q[p] <= rp_q[p] + FPW'(1);
            cnt_q[p] <= cnt_q[p] + FCW'(push[p]) - FCW'(gnt[p]);
         end
         if (tag_push) twp_q <= twp_q + TPW'(1);
         if (tag_pop) trp_q <= trp_q + TPW'(1);
         tcnt_q     <= tcnt_q + TCW'(tag_push) - TCW'(tag_pop);
         mem_wren_q <= |gnt & sel.wr;
         mem_rden_q <= tag_push;
         if (|gnt) begin
            mem_addr_q  <= sel.addr;
            mem_wdata_q <= sel.wdata;
            rr_last_q   <= gnt_id;
         end
         rvalid_q <= '0;
         if (tag_pop) begin
            rdata_q[tag_id]  <= bus.mem_rdata;
            rvalid_q[tag_id] <= 1'b1;
         end
         overflow_q <= overflow_q | (|(req_v & ~ready));
         orphan_q   <= orphan_q | (bus.mem_rdata_valid & (tcnt_q == '0));
      end
   end
   assign bus.a_req_ready   = ready[0];
   assign bus.b_req_ready   = ready[1];
   assign bus.a_rdata       = rdata_q[0];
   assign bus.b_rdata       = rdata_q[1];
   assign bus.a_rdata_valid = rvalid_q[0];
   assign bus.b_rdata_valid = rvalid_q[1];
   assign bus.mem_addr      = mem_addr_q;
   assign bus.mem_wdata     = mem_wdata_q;
   assign bus.mem_wren      = mem_wren_q;
   assign bus.mem_rden      = mem_rden_q;
   assign bus.overflow      = overflow_q;
   assign bus.orphan_resp   = orphan_q;
endmodule

// File: doc/l2_request_arbiter.md
Name: l2_request_arbiter

Overview:
- Sits between the two L1_cache snooper interfaces (L1a, L1b) and a single shared L2/memory port.
- Buffers each L1's line read/eviction requests in a per-port FIFO and issues them to memory one at a time under round-robin arbitration.
- Tracks outstanding reads in issue order and routes each returned cacheline to the L1 that requested it.
- Memory returns read data in request order with a fixed latency; writes are accepted on the cycle they are issued.

Parameters:
ADDR_W, 32, address width
LINE_W, 128, cacheline width
FIFO_DEPTH, 4, entries per L1 request FIFO (power of 2, >=2)
MAX_OUT, 8, max reads in flight to memory (power of 2)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
a_addr  in  ADDR_W  L1a snooper address
a_wdata  in  LINE_W  L1a evictable cacheline
a_wren  in  1  L1a eviction write pulse
a_rden  in  1  L1a line read pulse
a_req_ready  out  1  L1a FIFO can accept a request
a_rdata  out  LINE_W  cacheline returned to L1a
a_rdata_valid  out  1  a_rdata valid, 1-cycle pulse
b_addr, b_wdata, b_wren, b_rden, b_req_ready, b_rdata, b_rdata_valid: same as the a_* ports, for L1b
mem_addr  out  ADDR_W  memory address
mem_wdata  out  LINE_W  memory write data
mem_wren  out  1  memory write pulse
mem_rden  out  1  memory read pulse
mem_rdata  in  LINE_W  memory read data
mem_rdata_valid  in  1  memory read data valid
overflow  out  1  sticky: push attempted while FIFO full
orphan_resp  out  1  sticky: mem_rdata_valid with no outstanding read

Behaviour:
- Reset state:
  - All outputs are 0; a_req_ready and b_req_ready are 1.
  - Both FIFOs and the tag FIFO are empty.
  - rr_last = B, so A wins the first tie.
- Enqueue:
  - On any edge where x_wren|x_rden is high and x_req_ready=1, push {wr=x_wren, rd=x_rden, addr, wdata}.
  - When both wren and rden are set, this is one combined entry.
  - x_req_ready = !full and is derived from the registered count.
  - A push while full is dropped and sets overflow.
- Eligibility: a port is eligible if its FIFO is non-empty and (head.rd=0 or the tag FIFO is not full).
- Arbitration, at most one grant per cycle:
  - If only one port is eligible, it is granted.
  - If both are eligible, grant the port != rr_last.
  - rr_last updates to the granted port; it holds when there is no grant.
- Issue:
  - On a grant edge, mem_addr/mem_wdata load from the head; mem_wren=head.wr and mem_rden=head.rd.
  - The head is popped and, if rd=1, the port ID is pushed into the tag FIFO.
  - mem_wren and mem_rden are registered, one cycle wide, and 0 when there is no grant.
  - mem_addr and mem_wdata hold their last values.
- Latency:
  - A request sampled at edge k, with an empty FIFO and no contention, appears on mem_* after edge k+1.
  - One request per cycle sustained per port when the other port is idle.
  - Push and pop on the same edge are allowed; the count is unchanged.
- Response:
  - On an edge with mem_rdata_valid=1, pop the tag FIFO.
  - Register mem_rdata into x_rdata and pulse x_rdata_valid for one cycle for the tagged port only.
  - The other port's valid stays 0 and its rdata holds.
  - If the tag FIFO is empty: drop the data and set orphan_resp.
- A grant that pushes the tag FIFO on the same edge as a response that pops it is legal; occupancy is unchanged.
- A read is not issued if the tag FIFO is full, even when a response pops it that same edge, so occupancy never exceeds MAX_OUT.
- Write-only entries never wait on the tag FIFO.
- Ordering:
  - Per-port requests issue in FIFO order.
  - No address hazard checking across ports; arbitration order is the global order.
- Reset mid-operation flushes all FIFOs and tags, clears the sticky flags, and drives all outputs to reset values on the next cycle.

Test Plan:
- a_rden=1, a_addr=0x0000_1A40 at edge 1 -> mem_rden=1, mem_addr=0x1A40 during cycle after edge 2. Memory returns 0xDEADBEEF... 5 cycles later -> a_rdata_valid for 1 cycle with that data; b_rdata_valid stays 0.
- a_rden and b_rden on the same edge, addrs 0x100 and 0x200 -> mem_rden issues 0x100 then 0x200 on consecutive cycles. Responses route to A then B. The next simultaneous pair issues B first only if A won last.
- a_wren=1, a_wdata=0x11..11, addr 0x300 -> one mem_wren pulse with that data, mem_rden=0. No tag is pushed; a later orphan-free read proves tag count is unchanged.
- Hold mem_rdata_valid=0 and issue 9 reads from A -> exactly 8 mem_rden pulses, then the 9th issues on the cycle after the first response. A 5th pending entry beyond FIFO_DEPTH=4 drives a_req_ready=0; a push then sets overflow=1.
- Drive mem_rdata_valid=1 with no reads outstanding -> no x_rdata_valid, orphan_resp=1 and sticky until reset.
- Assert reset with 3 reads in flight -> all outputs 0, ready=1, flags 0. Next a_rden issues normally and its response routes to A.
